// File: rtl/i2c_target_regbridge.sv
// I2C target (7-bit address) bridging bus transactions to a parallel register-file port.
// Bus is oversampled on clk; SCL is never driven.
module i2c_target_regbridge #(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       reg_wr_en,
   output logic [7:0] reg_wr_addr,
   output logic [7:0] reg_wr_data,
   output logic [7:0] reg_rd_addr,
   input  logic [7:0] reg_rd_data,
   output logic       busy
);

   typedef enum logic [3:0] {
      StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
      StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
   } state_e;

   state_e state_q, state_d;
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d, tx_q, tx_d, ptr_q, ptr_d;
   logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
   logic mack_q, mack_d, sda_oe_q, sda_oe_d, busy_q, busy_d, wr_en_q, wr_en_d;
   logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, rx_bit, byte_done;

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign rx_bit    = scl_rise && (cnt_q != 4'd8) && (state_q inside {StAddr, StPtr, StWdata});
   assign byte_done = scl_fall && (cnt_q == 4'd8);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         cnt_q      <= '0;
         shift_q    <= '0;
         tx_q       <= '0;
         ptr_q      <= '0;
         mack_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         ptr_q      <= ptr_d;
         mack_q     <= mack_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      ptr_d      = ptr_q;
      mack_d     = mack_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      if (stop_det) begin
         state_d  = StIdle;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start_det) begin
         // Repeated START keeps the pointer so a write-pointer-then-read works.
         state_d  = StAddr;
         cnt_d    = '0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         if (rx_bit) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
         end
         case (state_q)
            StAddr: if (byte_done) begin
               if (shift_q[7:1] == SLAVE_ADDR && shift_q[7:1] != 7'd0) begin
                  sda_oe_d = 1'b1;
                  busy_d   = 1'b1;
                  state_d  = StAddrAck;
               end else begin
                  state_d = StIgnore;
               end
            end
            StAddrAck: if (scl_fall) begin
               sda_oe_d = 1'b0;
               cnt_d    = '0;
               if (shift_q[0]) begin
                  tx_d     = reg_rd_data;
                  sda_oe_d = ~reg_rd_data[7];
                  state_d  = StRdata;
               end else begin
                  state_d = StPtr;
               end
            end
            StPtr: if (byte_done) begin
               ptr_d    = shift_q;
               sda_oe_d = 1'b1;
               state_d  = StPtrAck;
            end
            StPtrAck: if (scl_fall) begin
               sda_oe_d = 1'b0;
               cnt_d    = '0;
               state_d  = StWdata;
            end
            StWdata: if (byte_done) begin
               sda_oe_d  = 1'b1;
               wr_en_d   = 1'b1;
               wr_addr_d = ptr_q;
               wr_data_d = shift_q;
               state_d   = StWdataAck;
            end
            StWdataAck: if (scl_fall) begin
               sda_oe_d = 1'b0;
               ptr_d    = ptr_q + 8'd1;
               cnt_d    = '0;
               state_d  = StWdata;
            end
            StRdata: if (scl_fall) begin
               if (cnt_q == 4'd7) begin
                  sda_oe_d = 1'b0;
                  state_d  = StRdataAck;
               end else begin
                  tx_d     = {tx_q[6:0], 1'b0};
                  sda_oe_d = ~tx_q[6];
                  cnt_d    = cnt_q + 4'd1;
               end
            end
            StRdataAck: begin
               if (scl_rise) begin
                  mack_d = sda_s;
                  ptr_d  = ptr_q + 8'd1;
               end else if (scl_fall) begin
                  if (!mack_q) begin
                     tx_d     = reg_rd_data;
                     sda_oe_d = ~reg_rd_data[7];
                     cnt_d    = '0;
                     state_d  = StRdata;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = StIgnore;
                  end
               end
            end
            StIgnore: sda_oe_d = 1'b0;
            default: ;
         endcase
      end
   end

   always_comb begin
      sda_oe      = sda_oe_q;
      busy        = busy_q;
      reg_wr_en   = wr_en_q;
      reg_wr_addr = wr_addr_q;
      reg_wr_data = wr_data_q;
      reg_rd_addr = ptr_q;
   end

endmodule

// File: tb/tb_i2c_target_regbridge.sv
// Directed bench for i2c_target_regbridge: bit-banged I2C master, wired-AND SDA,
// register file modelled as reg_rd_data = ~reg_rd_addr.
module tb_i2c_target_regbridge;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_in;
   logic       sda_oe;
   logic       reg_wr_en;
   logic [7:0] reg_wr_addr, reg_wr_data, reg_rd_addr, reg_rd_data;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   int         wr_cnt = 0;
   int         oe_cnt = 0;
   int         busy_cnt = 0;
   logic [7:0] wr_addr_log [16];
   logic [7:0] wr_data_log [16];

   assign sda_in      = sda_m & ~sda_oe;
   assign reg_rd_data = ~reg_rd_addr;

   always #5 clk = ~clk;

   i2c_target_regbridge #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .scl_in     (scl_m),
      .sda_in     (sda_in),
      .sda_oe     (sda_oe),
      .reg_wr_en  (reg_wr_en),
      .reg_wr_addr(reg_wr_addr),
      .reg_wr_data(reg_wr_data),
      .reg_rd_addr(reg_rd_addr),
      .reg_rd_data(reg_rd_data),
      .busy       (busy)
   );

   always @(posedge clk) begin
      if (reg_wr_en && wr_cnt < 16) begin
         wr_addr_log[wr_cnt] <= reg_wr_addr;
         wr_data_log[wr_cnt] <= reg_wr_data;
      end
      if (reg_wr_en) wr_cnt <= wr_cnt + 1;
      if (sda_oe) oe_cnt <= oe_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_cycle(input logic b, output logic rd);
      sda_m = b;
      wait_clk(4);
      scl_m = 1'b1;
      wait_clk(4);
      rd = sda_in;
      wait_clk(4);
      scl_m = 1'b0;
      wait_clk(4);
   endtask

   task automatic bus_start();
      sda_m = 1'b1;
      wait_clk(4);
      scl_m = 1'b1;
      wait_clk(4);
      sda_m = 1'b0;
      wait_clk(4);
      scl_m = 1'b0;
      wait_clk(4);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0;
      wait_clk(4);
      scl_m = 1'b1;
      wait_clk(4);
      sda_m = 1'b1;
      wait_clk(8);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic dummy;
      for (int i = 7; i >= 0; i--) bit_cycle(d[i], dummy);
      bit_cycle(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic dummy;
      for (int i = 7; i >= 0; i--) bit_cycle(1'b1, d[i]);
      bit_cycle(mack, dummy);
   endtask

   initial begin
      logic       ack;
      logic       dummy;
      logic [7:0] rd;
      int         base;
      int         oe_base;
      int         busy_base;

      wait_clk(4);
      reset = 1'b0;
      wait_clk(2);
      check("reset_sda_oe", sda_oe, 0);
      check("reset_wr_en", reg_wr_en, 0);
      check("reset_wr_addr", reg_wr_addr, 0);
      check("reset_wr_data", reg_wr_data, 0);
      check("reset_rd_addr", reg_rd_addr, 0);
      check("reset_busy", busy, 0);

      // Plain write: ptr 0x10, data A5, 3C
      base = wr_cnt;
      bus_start();
      write_byte(8'hA0, ack);
      check("t1_addr_ack", ack, 0);
      write_byte(8'h10, ack);
      check("t1_ptr_ack", ack, 0);
      check("t1_busy", busy, 1);
      write_byte(8'hA5, ack);
      check("t1_d0_ack", ack, 0);
      write_byte(8'h3C, ack);
      check("t1_d1_ack", ack, 0);
      bus_stop();
      check("t1_busy_after_stop", busy, 0);
      check("t1_strobes", wr_cnt - base, 2);
      check("t1_s0_addr", wr_addr_log[base], 8'h10);
      check("t1_s0_data", wr_data_log[base], 8'hA5);
      check("t1_s1_addr", wr_addr_log[base+1], 8'h11);
      check("t1_s1_data", wr_data_log[base+1], 8'h3C);

      // Wrong address 0x51: nothing happens
      base      = wr_cnt;
      oe_base   = oe_cnt;
      busy_base = busy_cnt;
      bus_start();
      write_byte(8'hA2, ack);
      check("t2_addr_nack", ack, 1);
      write_byte(8'h12, ack);
      check("t2_d0_nack", ack, 1);
      write_byte(8'h34, ack);
      check("t2_d1_nack", ack, 1);
      check("t2_oe_cycles", oe_cnt - oe_base, 0);
      check("t2_busy_cycles", busy_cnt - busy_base, 0);
      bus_stop();
      check("t2_strobes", wr_cnt - base, 0);

      // Write pointer 0x20, repeated START, read two bytes
      bus_start();
      write_byte(8'hA0, ack);
      write_byte(8'h20, ack);
      check("t3_ptr_ack", ack, 0);
      bus_start();
      write_byte(8'hA1, ack);
      check("t3_raddr_ack", ack, 0);
      read_byte(1'b0, rd);
      check("t3_rd0", rd, 8'hDF);
      read_byte(1'b1, rd);
      check("t3_rd1", rd, 8'hDE);
      check("t3_oe_after_nack", sda_oe, 0);
      check("t3_rd_addr", reg_rd_addr, 8'h22);
      check("t3_busy_after_nack", busy, 0);
      bus_stop();

      // Pointer wrap
      base = wr_cnt;
      bus_start();
      write_byte(8'hA0, ack);
      write_byte(8'hFF, ack);
      write_byte(8'h11, ack);
      write_byte(8'h22, ack);
      check("t4_d1_ack", ack, 0);
      bus_stop();
      check("t4_strobes", wr_cnt - base, 2);
      check("t4_s0_addr", wr_addr_log[base], 8'hFF);
      check("t4_s0_data", wr_data_log[base], 8'h11);
      check("t4_s1_addr", wr_addr_log[base+1], 8'h00);
      check("t4_s1_data", wr_data_log[base+1], 8'h22);

      // STOP inside a data byte
      base = wr_cnt;
      bus_start();
      write_byte(8'hA0, ack);
      write_byte(8'h40, ack);
      for (int i = 0; i < 5; i++) bit_cycle(i[0], dummy);
      bus_stop();
      check("t5_strobes", wr_cnt - base, 0);
      check("t5_sda_oe", sda_oe, 0);
      check("t5_busy", busy, 0);
      bus_start();
      write_byte(8'hA0, ack);
      check("t5_readdr_ack", ack, 0);
      write_byte(8'h41, ack);
      check("t5_ptr_ack", ack, 0);
      check("t5_rd_addr", reg_rd_addr, 8'h41);
      bus_stop();

      // Reset while driving a 0 in a read byte (~0x30 = 0xCF, bit5 = 0)
      bus_start();
      write_byte(8'hA0, ack);
      write_byte(8'h30, ack);
      bus_start();
      write_byte(8'hA1, ack);
      bit_cycle(1'b1, rd[7]);
      bit_cycle(1'b1, rd[6]);
      check("t6_rd_bits", rd[7:6], 2'b11);
      check("t6_driving_zero", sda_oe, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("t6_oe_released", sda_oe, 0);
      check("t6_busy", busy, 0);
      check("t6_rd_addr", reg_rd_addr, 0);
      check("t6_wr_addr", reg_wr_addr, 0);
      check("t6_wr_data", reg_wr_data, 0);
      check("t6_wr_en", reg_wr_en, 0);
      @(negedge clk);
      reset     = 1'b0;
      oe_base   = oe_cnt;
      busy_base = busy_cnt;
      for (int i = 0; i < 6; i++) bit_cycle(1'b1, dummy);
      bit_cycle(1'b0, dummy);
      check("t6_oe_ignored", oe_cnt - oe_base, 0);
      check("t6_busy_ignored", busy_cnt - busy_base, 0);
      bus_stop();
      bus_start();
      write_byte(8'hA0, ack);
      check("t6_new_addr_ack", ack, 0);
      bus_stop();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
